fsm_fetch_dispatch: RTL and testbench
=====================================

FSM_FETCH_DISPATCH -- requirements
Module: fsm_fetch_dispatch

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, asynchronous, active-high.
REQ-003 The block SHALL have the port imem_req, output, 1 bit, instruction fetch request.
REQ-004 The block SHALL have the port imem_ack, input, 1 bit, fetch data valid.
REQ-005 The block SHALL have the port imem_rdata, input, 32 bits, fetched instruction word.
REQ-006 The block SHALL have the port ins, output, 32 bits, instruction register driving the sub-FSMs.
REQ-007 The block SHALL have the port code, output, 32 bits, one-hot instruction class driving the sub-FSMs.
REQ-008 The block SHALL have the ports start_alu, start_mem and start_bj, outputs, 1 bit each, sub-FSM start pulses.
REQ-009 The block SHALL have the ports done_alu, done_mem and done_bj, inputs, 1 bit each, sub-FSM completion pulses.
REQ-010 The block SHALL have the port busy, output, 1 bit, high in every state except IDLE and TRAP.
REQ-011 The block SHALL have the port trap, output, 1 bit, sticky error flag for an illegal opcode or a watchdog expiry.
REQ-012 The block SHALL have the parameter WDOG_MAX, default 15, maximum number of WAIT_DONE cycles before a trap.

Function
REQ-013 The block SHALL implement the states IDLE, FETCH, DECODE, DISPATCH, WAIT_DONE and TRAP, with registered state and combinational next-state logic.
REQ-014 The state SHALL go from IDLE to FETCH on the first clock after reset is released.
REQ-015 In FETCH, imem_req SHALL be held high until the cycle imem_ack=1.
REQ-016 In the imem_ack cycle, ins SHALL load imem_rdata and the state SHALL go to DECODE.
REQ-017 imem_req SHALL be low in all states other than FETCH.
REQ-018 In DECODE, code SHALL be registered from ins[6:0]: exactly one bit set for a legal opcode, all zero otherwise.
REQ-019 The class bits SHALL be: bit 24 = B-type (1100011), bit 25 = JAL (1101111), bit 26 = JALR (1100111); the ALU, load/store and LUI bit indices SHALL be fixed by package constants.
REQ-020 From DECODE, the state SHALL go to TRAP if code is all zero, and to DISPATCH otherwise.
REQ-021 In DISPATCH, exactly one start_* SHALL be high for exactly one cycle, selected from code: B/JAL/JALR to start_bj, load/store to start_mem, all other classes to start_alu.
REQ-022 The state SHALL then go to WAIT_DONE.
REQ-023 In WAIT_DONE, only the done_* matching the dispatched unit SHALL be honoured; all other done_* inputs SHALL be ignored.
REQ-024 On the matching done_*, the state SHALL go to FETCH on the next clock.
REQ-025 ins and code SHALL hold stable from DECODE until the next imem_ack.
REQ-026 A 4-bit watchdog SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle.
REQ-027 When the watchdog reaches WDOG_MAX without a matching done, the state SHALL go to TRAP.
REQ-028 If a matching done arrives in the same cycle as the expiry, done SHALL take priority over the expiry.
REQ-029 TRAP SHALL be absorbing: trap=1, no start_* and no imem_req are issued until reset.
REQ-030 Minimum latency from imem_ack to start_* SHALL be 2 cycles (DECODE, then DISPATCH).
REQ-031 Minimum instruction period SHALL be 4 cycles plus the memory wait plus the sub-FSM duration.

Reset
REQ-032 Asserting reset SHALL force the state to IDLE immediately, even mid-fetch or mid-wait.
REQ-033 Reset SHALL force ins=0, code=0, all start_*=0, imem_req=0, busy=0, trap=0 and watchdog=0.
REQ-034 A done_* or imem_ack arriving during reset or in IDLE SHALL be ignored.

Structure
REQ-035 The state encoding, opcode constants, code bit indices and WDOG_MAX default SHALL live in the shared control-unit package.
REQ-036 The combinational opcode-to-one-hot mapping SHALL be one sub-module, opcode_classifier.

Verification
REQ-037 The bench SHALL cover: imem_rdata=0x00208463 (BEQ), ack after 2 wait cycles -> code[24]=1, start_bj pulses 2 cycles after ack, done_bj 4 cycles later, then imem_req on the next cycle.
REQ-038 The bench SHALL cover: JAL 0x008000EF -> code[25]=1, start_bj single-cycle, start_alu and start_mem stay 0.
REQ-039 The bench SHALL cover: illegal word 0x0000007F -> code=0, trap=1 one cycle after DECODE, no start_*, imem_req stuck at 0.
REQ-040 The bench SHALL cover: LW dispatched, done_alu pulsed (wrong unit) and done_mem withheld -> trap=1 after 15 WAIT_DONE cycles.
REQ-041 The bench SHALL cover: done_mem asserted on watchdog cycle 15 -> return to FETCH, trap=0.
REQ-042 The bench SHALL cover: reset asserted asynchronously mid-WAIT_DONE -> all outputs 0 before the next clock edge, and FETCH resumes one clock after release.

Source files
------------

// File: rtl/fsm_fetch_dispatch_pkg.sv
// Shared control-unit definitions for the fetch/dispatch FSM: state encoding,
// RISC-V major opcodes, one-hot class bit positions and execution-unit selection.
package fsm_fetch_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DISPATCH,
    ST_WAIT_DONE,
    ST_TRAP
  } state_t;

  typedef enum logic [1:0] {
    UNIT_NONE,
    UNIT_ALU,
    UNIT_MEM,
    UNIT_BJ
  } unit_t;

  localparam int unsigned WDOG_MAX_DEFAULT = 15;
  localparam int unsigned WDOG_W           = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int unsigned CODE_OP     = 19;
  localparam int unsigned CODE_OP_IMM = 20;
  localparam int unsigned CODE_LOAD   = 21;
  localparam int unsigned CODE_STORE  = 22;
  localparam int unsigned CODE_LUI    = 23;
  localparam int unsigned CODE_BRANCH = 24;
  localparam int unsigned CODE_JAL    = 25;
  localparam int unsigned CODE_JALR   = 26;
  localparam int unsigned CODE_AUIPC  = 27;

  // Control-flow classes go to the branch/jump unit, memory classes to the
  // load/store unit, and every other legal class to the ALU.
  function automatic unit_t unit_of(input logic [31:0] code);
    unit_t u;
    u = UNIT_NONE;
    if (code[CODE_BRANCH] | code[CODE_JAL] | code[CODE_JALR]) begin
      u = UNIT_BJ;
    end else if (code[CODE_LOAD] | code[CODE_STORE]) begin
      u = UNIT_MEM;
    end else if (|code) begin
      u = UNIT_ALU;
    end
    return u;
  endfunction

endpackage

// File: rtl/fsm_fetch_dispatch_opcode_classifier.sv
// Combinational opcode-to-one-hot class mapping; unknown opcodes give all zeros.
module opcode_classifier
  import fsm_fetch_dispatch_pkg::*;
(
  input  logic [6:0]  opcode,
  output logic [31:0] code
);

  always_comb begin
    code = '0;
    case (opcode)
      OPC_OP:     code[CODE_OP]     = 1'b1;
      OPC_OP_IMM: code[CODE_OP_IMM] = 1'b1;
      OPC_LOAD:   code[CODE_LOAD]   = 1'b1;
      OPC_STORE:  code[CODE_STORE]  = 1'b1;
      OPC_LUI:    code[CODE_LUI]    = 1'b1;
      OPC_AUIPC:  code[CODE_AUIPC]  = 1'b1;
      OPC_BRANCH: code[CODE_BRANCH] = 1'b1;
      OPC_JAL:    code[CODE_JAL]    = 1'b1;
      OPC_JALR:   code[CODE_JALR]   = 1'b1;
      default:    code = '0;
    endcase
  end

endmodule

// File: rtl/fsm_fetch_dispatch.sv
// Control-unit sequencer: fetches an instruction word, classifies it, starts the
// matching sub-FSM and waits for its completion under a watchdog.
module fsm_fetch_dispatch
  import fsm_fetch_dispatch_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] code,
  output logic        start_alu,
  output logic        start_mem,
  output logic        start_bj,
  input  logic        done_alu,
  input  logic        done_mem,
  input  logic        done_bj,
  output logic        busy,
  output logic        trap
);

  localparam logic [WDOG_W:0] WDOG_LIMIT = WDOG_MAX[WDOG_W:0];

  state_t              state_q;
  state_t              state_next;
  logic [31:0]         class_code;
  unit_t               unit_sel;
  logic                done_match;
  logic [WDOG_W-1:0]   wdog_q;
  logic [WDOG_W:0]     wdog_inc;
  logic                wdog_expire;

  opcode_classifier u_classifier (
    .opcode (ins[6:0]),
    .code   (class_code)
  );

  // code is frozen from DECODE until the next fetch, so the unit can be derived from it
  assign unit_sel    = unit_of(code);
  assign wdog_inc    = {1'b0, wdog_q} + {{WDOG_W{1'b0}}, 1'b1};
  assign wdog_expire = (wdog_inc == WDOG_LIMIT);

  always_comb begin
    done_match = 1'b0;
    case (unit_sel)
      UNIT_ALU: done_match = done_alu;
      UNIT_MEM: done_match = done_mem;
      UNIT_BJ:  done_match = done_bj;
      default:  done_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    imem_req   = 1'b0;
    start_alu  = 1'b0;
    start_mem  = 1'b0;
    start_bj   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // decision uses the class being registered this cycle
        state_next = (class_code == '0) ? ST_TRAP : ST_DISPATCH;
      end
      ST_DISPATCH: begin
        case (unit_sel)
          UNIT_ALU: start_alu = 1'b1;
          UNIT_MEM: start_mem = 1'b1;
          UNIT_BJ:  start_bj  = 1'b1;
          default:  start_alu = 1'b0;
        endcase
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // a completion on the expiry cycle still counts
        if (done_match) begin
          state_next = ST_FETCH;
        end else if (wdog_expire) begin
          state_next = ST_TRAP;
        end
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign trap = (state_q == ST_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins    <= '0;
      code   <= '0;
      wdog_q <= '0;
    end else begin
      if ((state_q == ST_FETCH) && imem_ack) begin
        ins <= imem_rdata;
      end
      if (state_q == ST_DECODE) begin
        code <= class_code;
      end
      if (state_q == ST_DISPATCH) begin
        wdog_q <= '0;
      end else if (state_q == ST_WAIT_DONE) begin
        wdog_q <= wdog_inc[WDOG_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fsm_fetch_dispatch.sv
// Directed bench for fsm_fetch_dispatch: expected start/class per fetched word are
// queued at fetch time and checked when a start pulse appears.
module tb_fsm_fetch_dispatch;
  import fsm_fetch_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] code;
  logic        start_alu, start_mem, start_bj;
  logic        done_alu, done_mem, done_bj;
  logic        busy;
  logic        trap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  start;
    logic [31:0] code;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fsm_fetch_dispatch #(.WDOG_MAX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .code       (code),
    .start_alu  (start_alu),
    .start_mem  (start_mem),
    .start_bj   (start_bj),
    .done_alu   (done_alu),
    .done_mem   (done_mem),
    .done_bj    (done_bj),
    .busy       (busy),
    .trap       (trap)
  );

  function automatic logic [31:0] model_code(input logic [31:0] w);
    logic [31:0] c;
    c = '0;
    case (w[6:0])
      7'b1100011: c[24] = 1'b1;
      7'b1101111: c[25] = 1'b1;
      7'b1100111: c[26] = 1'b1;
      7'b0000011: c[CODE_LOAD] = 1'b1;
      7'b0100011: c[CODE_STORE] = 1'b1;
      7'b0110111: c[CODE_LUI] = 1'b1;
      7'b0110011: c[CODE_OP] = 1'b1;
      7'b0010011: c[CODE_OP_IMM] = 1'b1;
      7'b0010111: c[CODE_AUIPC] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // {bj, mem, alu}
  function automatic logic [2:0] model_start(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111) return 3'b100;
    if (op == 7'b0000011 || op == 7'b0100011) return 3'b010;
    if (model_code(w) != '0) return 3'b001;
    return 3'b000;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_starts_low(input string tag);
    chk32(tag, {29'b0, start_bj, start_mem, start_alu}, 32'h0);
  endtask

  // Entered at a negedge in FETCH; returns at the negedge of the DECODE cycle.
  task automatic fetch(input logic [31:0] w, input int unsigned waits);
    exp_t e;
    for (int unsigned i = 0; i < waits; i++) begin
      chk1("fetch_req_wait", imem_req, 1'b1);
      imem_ack = 1'b0;
      step();
    end
    chk1("fetch_req_ack", imem_req, 1'b1);
    imem_rdata = w;
    imem_ack   = 1'b1;
    if (model_code(w) != '0) begin
      e.start = model_start(w);
      e.code  = model_code(w);
      sb.push_back(e);
    end
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk32("decode_ins", ins, w);
    chk1("decode_req_low", imem_req, 1'b0);
    chk1("decode_busy", busy, 1'b1);
    chk_starts_low("decode_no_start");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk1("rst_fetch_req", imem_req, 1'b1);
    chk1("rst_trap_clear", trap, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (start_alu || start_mem || start_bj)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_start: observed start %b expected none",
               {start_bj, start_mem, start_alu});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk32("sb_start", {29'b0, start_bj, start_mem, start_alu}, {29'b0, e.start});
        chk32("sb_code", code, e.code);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish within 100us");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    done_alu   = 1'b1;
    done_mem   = 1'b1;
    done_bj    = 1'b1;
    step();
    step();
    chk32("rst_ins", ins, 32'h0);
    chk32("rst_code", code, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_trap", trap, 1'b0);
    chk_starts_low("rst_starts");

    // Release with ack still high: the IDLE cycle must ignore it
    reset = 1'b0;
    #1;
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_req", imem_req, 1'b0);
    step();
    chk1("first_fetch_req", imem_req, 1'b1);
    chk32("idle_ack_ignored", ins, 32'h0);
    imem_ack = 1'b0;
    done_alu = 1'b0;
    done_mem = 1'b0;
    done_bj  = 1'b0;

    // BEQ, ack after 2 wait cycles, done_bj 4 cycles after start
    fetch(32'h0020_8463, 2);
    step();
    chk1("beq_start_bj", start_bj, 1'b1);
    chk32("beq_code", code, 32'h0100_0000);
    step();
    chk_starts_low("beq_start_single");
    step();
    step();
    step();
    done_bj = 1'b1;
    chk1("beq_wait_req_low", imem_req, 1'b0);
    step();
    done_bj = 1'b0;
    chk1("beq_refetch", imem_req, 1'b1);
    chk32("beq_code_hold", code, 32'h0100_0000);

    // JAL: only start_bj, exactly one cycle
    fetch(32'h0080_00EF, 0);
    step();
    chk1("jal_start_bj", start_bj, 1'b1);
    chk1("jal_start_alu", start_alu, 1'b0);
    chk1("jal_start_mem", start_mem, 1'b0);
    chk32("jal_code", code, 32'h0200_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_starts_low("jal_wait_starts");
      chk1("jal_wait_busy", busy, 1'b1);
    end
    done_bj = 1'b1;
    step();
    done_bj = 1'b0;
    chk1("jal_refetch", imem_req, 1'b1);

    // ADDI: wrong-unit completions are ignored
    fetch(32'h0010_0093, 1);
    step();
    chk1("addi_start_alu", start_alu, 1'b1);
    step();
    done_mem = 1'b1;
    done_bj  = 1'b1;
    step();
    done_mem = 1'b0;
    done_bj  = 1'b0;
    chk1("addi_wrong_done_ignored", imem_req, 1'b0);
    chk1("addi_still_busy", busy, 1'b1);
    done_alu = 1'b1;
    step();
    done_alu = 1'b0;
    chk1("addi_refetch", imem_req, 1'b1);

    // LW with done_mem withheld: trap after 15 WAIT_DONE cycles
    fetch(32'h0000_A103, 0);
    step();
    chk1("lw_start_mem", start_mem, 1'b1);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk1("lw_wd_no_trap", trap, 1'b0);
      chk1("lw_wd_busy", busy, 1'b1);
      done_alu = n[0];
      done_bj  = (n == 7);
    end
    done_alu = 1'b0;
    done_bj  = 1'b0;
    step();
    chk1("lw_wd_trap", trap, 1'b1);
    chk1("lw_wd_trap_busy", busy, 1'b0);
    imem_ack = 1'b1;
    done_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("trap_sticky", trap, 1'b1);
      chk1("trap_no_req", imem_req, 1'b0);
      chk_starts_low("trap_no_start");
    end
    imem_ack = 1'b0;
    done_mem = 1'b0;
    do_reset();

    // LW with done_mem on watchdog cycle 15: done wins
    fetch(32'h0000_A103, 0);
    step();
    chk1("lw15_start_mem", start_mem, 1'b1);
    for (int n = 1; n <= 15; n++) step();
    chk1("lw15_still_waiting", busy, 1'b1);
    done_mem = 1'b1;
    step();
    done_mem = 1'b0;
    chk1("lw15_refetch", imem_req, 1'b1);
    chk1("lw15_no_trap", trap, 1'b0);
    chk1("lw15_busy", busy, 1'b1);

    // Illegal opcode
    fetch(32'h0000_007F, 0);
    step();
    chk1("ill_trap", trap, 1'b1);
    chk32("ill_code", code, 32'h0);
    chk1("ill_busy", busy, 1'b0);
    imem_ack = 1'b1;
    done_alu = 1'b1;
    done_mem = 1'b1;
    done_bj  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("ill_req_stuck", imem_req, 1'b0);
      chk1("ill_trap_sticky", trap, 1'b1);
      chk_starts_low("ill_no_start");
    end
    imem_ack = 1'b0;
    done_alu = 1'b0;
    done_mem = 1'b0;
    done_bj  = 1'b0;
    do_reset();

    // Asynchronous reset in the middle of WAIT_DONE
    fetch(32'h0000_A103, 0);
    step();
    chk1("ar_start_mem", start_mem, 1'b1);
    step();
    step();
    chk1("ar_waiting", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk32("ar_ins", ins, 32'h0);
    chk32("ar_code", code, 32'h0);
    chk1("ar_req", imem_req, 1'b0);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_trap", trap, 1'b0);
    chk_starts_low("ar_starts");
    step();
    reset = 1'b0;
    #1;
    chk1("ar_idle_req", imem_req, 1'b0);
    step();
    chk1("ar_resume_fetch", imem_req, 1'b1);
    chk1("ar_resume_busy", busy, 1'b1);

    chk32("sb_drained", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
